// File: rtl/demux1_2_32bits_stream_pkg.sv
// ============================================================================
// demux1_2_32bits_stream_pkg : shared select encoding and default sizes
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux1_2_32bits_stream_pkg;

  // Same sense as the datapath 2:1 muxes: sel=0 picks side A
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/demux1_2_32bits_stream_fifo.sv
// ============================================================================
// fifo_sync_32bits : single-clock FIFO with occupancy, one per output channel
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_sync_32bits
  import demux1_2_32bits_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign dout      = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even if it pops on the same edge
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared so the head reads 0 until the first write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux1_2_32bits_stream.sv
// ============================================================================
// demux1_2_32bits_stream : steers one valid/ready stream into two FIFO-buffered
// output channels by a per-word select bit, with per-channel word counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux1_2_32bits_stream
  import demux1_2_32bits_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             a_full, b_full;
  logic             a_empty, b_empty;
  logic [OCC_W-1:0] a_occ, b_occ;
  logic             accept;
  logic             push_a, push_b;
  logic             pop_a, pop_b;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;
  logic             unused_occ;

  // Head-of-line: only the selected FIFO's fullness matters, and the
  // consumer ready signals never reach in_ready
  assign in_ready = (in_sel == SEL_B) ? ~b_full : ~a_full;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (in_sel == SEL_A);
  assign push_b   = accept & (in_sel == SEL_B);

  assign a_valid = ~a_empty;
  assign b_valid = ~b_empty;
  assign pop_a   = a_valid & a_ready;
  assign pop_b   = b_valid & b_ready;

  assign unused_occ = ^{a_occ, b_occ};

  fifo_sync_32bits #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .din       (in_data),
    .full      (a_full),
    .pop       (pop_a),
    .dout      (a_data),
    .empty     (a_empty),
    .occupancy (a_occ)
  );

  fifo_sync_32bits #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .din       (in_data),
    .full      (b_full),
    .pop       (pop_b),
    .dout      (b_data),
    .empty     (b_empty),
    .occupancy (b_occ)
  );

  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (push_a) a_count_d = a_count_q + CNT_ONE;
    if (push_b) b_count_d = b_count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;

endmodule

`default_nettype wire

// File: tb/tb_demux1_2_32bits_stream.sv
// ============================================================================
// tb_demux1_2_32bits_stream : directed + random stimulus against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux1_2_32bits_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus wrapping counters
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [CNT_W-1:0] ca = '0;
  logic [CNT_W-1:0] cb = '0;

  demux1_2_32bits_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance DUT and model by one edge
  task automatic cycle();
    bit               acc, pa, pb, sel;
    logic [WIDTH-1:0] d;
    #1;
    chk("a_valid", a_valid, qa.size() != 0);
    chk("b_valid", b_valid, qb.size() != 0);
    if (qa.size() != 0) chk("a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
    chk("in_ready", in_ready, in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    chk("a_count", a_count, ca);
    chk("b_count", b_count, cb);
    sel = in_sel;
    d   = in_data;
    acc = in_valid && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    pa  = (qa.size() != 0) && a_ready;
    pb  = (qb.size() != 0) && b_ready;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      ca = '0;
      cb = '0;
    end else begin
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
        if (sel) begin qb.push_back(d); cb++; end
        else     begin qa.push_back(d); ca++; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    a_ready = 1'b0; b_ready = 1'b0;

    // 1: reset with in_valid high, then idle
    @(posedge clk);
    @(negedge clk);
    cycle();
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_b_data", b_data, 32'h0);
    chk("rst_a_count", a_count, 16'h0);
    chk("rst_b_count", b_count, 16'h0);
    rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0;
    #1 chk("idle_rdy_sel0", in_ready, 1'b1);
    in_sel = 1'b1;
    #1 chk("idle_rdy_sel1", in_ready, 1'b1);
    cycle();

    // 2: basic routing
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_1111;
    cycle();
    chk("basic_a_valid", a_valid, 1'b1);
    chk("basic_a_data", a_data, 32'h1111_1111);
    in_sel = 1'b1; in_data = 32'h2222_2222;
    cycle();
    chk("basic_b_valid", b_valid, 1'b1);
    chk("basic_b_data", b_data, 32'h2222_2222);
    chk("basic_a_count", a_count, 16'd1);
    chk("basic_b_count", b_count, 16'd1);
    in_valid = 1'b0;
    cycle();

    // 3: back-pressure on A, third word stalls
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'hA0; cycle();
    in_data = 32'hA1; cycle();
    in_data = 32'hA2;
    #1 chk("full_in_ready", in_ready, 1'b0);
    cycle();
    cycle();
    chk("stall_hold_a_data", a_data, 32'hA0);
    a_ready = 1'b1;
    cycle();
    chk("drain_a_data1", a_data, 32'hA1);
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 4: head-of-line blocking
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'h40; cycle();
    in_data = 32'h41; cycle();
    in_data = 32'h42;
    #1 chk("hol_blocked", in_ready, 1'b0);
    cycle();
    in_sel = 1'b1; in_data = 32'hB0;
    #1 chk("hol_b_ready", in_ready, 1'b1);
    cycle();
    chk("hol_b_data", b_data, 32'hB0);
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    repeat (3) cycle();

    // 5: simultaneous push/pop at occupancy 1
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC0;
    cycle();
    a_ready = 1'b1; in_data = 32'hC1;
    cycle();
    chk("pushpop_a_valid", a_valid, 1'b1);
    chk("pushpop_a_data", a_data, 32'hC1);
    in_valid = 1'b0; a_ready = 1'b0;
    cycle();
    chk("pushpop_occ1", a_data, 32'hC1);
    a_ready = 1'b1;
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      cycle();
    end

    // 6: reset mid-operation
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = 1'(i / 2);
      in_data = $urandom;
      cycle();
    end
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    chk("midrst_a_valid", a_valid, 1'b0);
    chk("midrst_b_valid", b_valid, 1'b0);
    chk("midrst_a_count", a_count, 16'h0);
    chk("midrst_b_count", b_count, 16'h0);

    // Counter wrap: 65536 accepts into B
    b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    chk("wrap_b_count", b_count, 16'h0);
    chk("wrap_a_count", a_count, 16'h0);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
